// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
// MULT/MULTU run a 32-step shift-add and DIV/DIVU run a 32-step restoring
// divide, both on operand magnitudes. A final FIX cycle applies the sign
// correction and writes HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // op_q[1]: divide, op_q[0]: signed
  logic [1:0]  op_q, op_d;
  logic [31:0] mcand_q, mcand_d;      // multiplicand or divisor magnitude
  logic [63:0] prod_q, prod_d;        // product, or {rem, quot} for divide
  logic        neg_res_q, neg_res_d;  // product / quotient must be negated
  logic        neg_rem_q, neg_rem_d;  // remainder must be negated
  logic        div0_q, div0_d;
  logic [31:0] araw_q, araw_d;        // original dividend for the b=0 result
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept_md;
  logic [32:0] mul_sum;
  logic        div_ge;
  logic [31:0] div_rem;

  // Magnitude of a 32-bit operand; 0x8000_0000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    logic signed [31:0] s;
    s = v;
    return (sgn && (s < 0)) ? (32'd0 - v) : v;
  endfunction

  // Conditional two's-complement negation, 32 bits.
  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic n);
    return n ? (32'd0 - v) : v;
  endfunction

  // Conditional two's-complement negation, 64 bits.
  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic n);
    return n ? (64'd0 - v) : v;
  endfunction

  assign accept_md = (state_q == S_IDLE) && start && !op[2];

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> CALC on a mult/div start, 32 CALC steps, one FIX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept_md) state_d = S_CALC;
      S_CALC: if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Iteration arithmetic for one CALC step.
  always_comb begin
    mul_sum = {1'b0, prod_q[63:32]} + {1'b0, mcand_q};
    div_ge  = ({prod_q[63:31]}) >= {1'b0, mcand_q};
    div_rem = prod_q[62:31] - mcand_q;
  end

  // Operand latch on accept, then the shift-add / restoring-divide datapath.
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    araw_d    = araw_q;
    if (accept_md) begin
      cnt_d     = 6'd0;
      op_d      = op[1:0];
      mcand_d   = op[1] ? mag32(b, op[0]) : mag32(a, op[0]);
      prod_d    = {32'd0, (op[1] ? mag32(a, op[0]) : mag32(b, op[0]))};
      neg_res_d = op[0] & (a[31] ^ b[31]);
      neg_rem_d = op[0] & a[31];
      div0_d    = (b == 32'd0);
      araw_d    = a;
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q + 6'd1;
      if (op_q[1]) begin
        // Shift {rem, quot} left and keep the trial difference if it fits.
        prod_d = div_ge ? {div_rem, prod_q[30:0], 1'b1}
                        : {prod_q[62:31], prod_q[30:0], 1'b0};
      end else begin
        // Add multiplicand into the upper half when the low bit is set, shift right.
        prod_d = prod_q[0] ? {mul_sum, prod_q[31:1]}
                           : {1'b0, prod_q[63:1]};
      end
    end
  end

  // Output logic: HI/LO writes, done pulse and registered busy.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIX);
    if ((state_q == S_IDLE) && start) begin
      if (op == OP_MTHI) hi_d = a;
      if (op == OP_MTLO) lo_d = a;
    end else if (state_q == S_FIX) begin
      if (!op_q[1]) begin
        {hi_d, lo_d} = cneg64(prod_q, neg_res_q);
      end else if (div0_q) begin
        hi_d = araw_q;
        lo_d = 32'hFFFF_FFFF;
      end else begin
        lo_d = cneg32(prod_q[31:0], neg_res_q);
        hi_d = cneg32(prod_q[63:32], neg_rem_q);
      end
    end
  end

  // Datapath and output registers, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 6'd0;
      op_q      <= 2'd0;
      mcand_q   <= 32'd0;
      prod_q    <= 64'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      araw_q    <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      araw_q    <= araw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int n_cyc;
  int n_busy;

  muldiv_unit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle, then scramble the inputs.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'b110; a = ~x; b = ~y;
  endtask

  // From the current negedge, count further negedges until done is seen.
  task automatic wait_done(output int n, output int nb);
    n  = -1;
    nb = 0;
    for (int i = 0; i < 80; i++) begin
      if (busy) nb++;
      if (done) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_chk(input string t, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int n;
    int nb;
    issue(o, x, y);
    wait_done(n, nb);
    chk({t, "_lat"}, n, 33);
    chk({t, "_hi"}, hi, eh);
    chk({t, "_lo"}, lo, el);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;

    // Preload HI so the mid-operation reset has something to clear
    issue(3'b100, 32'h55, 32'd0);
    chk("mthi_hi", hi, 32'h55);
    chk("mthi_busy", busy, 0);

    // Reset mid-operation
    issue(3'b000, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(3'b101, 32'd7, 32'd0);
    chk("mtlo_lo", lo, 32'd7);
    chk("mtlo_busy", busy, 0);

    // MULTU full width with busy/done timing
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n_cyc, n_busy);
    chk("multu_lat", n_cyc, 33);
    chk("multu_busycyc", n_busy, 33);
    chk("multu_busy_at_done", busy, 0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    @(negedge clk);
    chk("multu_done_pulse", done, 0);

    run_chk("mult_n7x6",  3'b001, 32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_chk("mult_n7xn6", 3'b001, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd0,        32'd42);
    run_chk("div_n17_5",  3'b011, 32'hFFFF_FFEF, 32'd5,        32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_chk("divu_100_7", 3'b010, 32'd100,       32'd7,        32'd2,        32'd14);
    run_chk("div_min_m1", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
    run_chk("divu_by0",   3'b010, 32'h1234,      32'd0,        32'h1234,     32'hFFFF_FFFF);

    // Start while busy is ignored; HI holds until FIX
    issue(3'b000, 32'd3, 32'd5);
    repeat (3) @(negedge clk);
    issue(3'b100, 32'd9, 32'd0);
    chk("ign_hi_hold", hi, 32'h1234);
    chk("ign_busy", busy, 1);
    wait_done(n_cyc, n_busy);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd15);

    // Back-to-back: new DIVU in the done cycle
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 3'b110; a = 32'd0; b = 32'd0;
    chk("b2b_busy", busy, 1);
    wait_done(n_cyc, n_busy);
    chk("b2b_lat", n_cyc, 33);
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS CPU. It sits in the EX stage directly downstream of the register file and consumes the rs/rt read-port values (RD1/RD2) as its operands. It executes MULT, MULTU, DIV, DIVU as a 32-iteration sequential operation and MTHI/MTLO as single-cycle writes. While it runs it holds `busy`, which the hazard logic uses to stall MFHI/MFLO and any further mult/div.

## Interface
- Parameters: none. Width is fixed at 32 bits and the iteration count is fixed at 32.
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only at a posedge while idle.
- `op`  in  3  operation select: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op.
- `a`  in  32  rs operand (register file RD1).
- `b`  in  32  rt operand (register file RD2).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when HI/LO are updated by a mult/div.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- **State machine:** IDLE, CALC, FIX. `busy` = (state != IDLE). All outputs come from registers.
- **IDLE, start=1:**
  - MTHI: `hi` <= `a`; the machine stays in IDLE. MTLO: `lo` <= `a`; the machine stays in IDLE. `done` is not pulsed for either.
  - mult/div ops: latch |a| and |b| (absolute value for signed ops, raw value for unsigned ops), the result-sign flags, and the op. Clear the 6-bit counter and enter CALC.
  - 11x: ignored.
- **CALC, multiply:** 64-bit shift-add. Each cycle, if product[0] is set, add the multiplicand to the upper 33 bits, then shift the product right by 1.
- **CALC, divide:** restoring division. Each cycle, shift {rem, quot} left by 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set quot[0].
- **CALC exit:** after 32 CALC cycles (counter reaches 31), go to FIX.
- **FIX:** apply sign correction and write the results, then return to IDLE with `done`=1.
  - Multiply: {hi, lo} <= product. For MULT, negate the 64-bit product if a[31]^b[31].
  - Divide: lo <= quotient, negated if a[31]^b[31] (DIV only). hi <= remainder, negated if a[31] (DIV only).
- **Divide by zero (b=0), DIVU and DIV:** still takes the full latency. Result is fixed at hi <= `a` (original, uncorrected) and lo <= 32'hFFFF_FFFF.
- **DIV 0x8000_0000 / 0xFFFF_FFFF:** lo = 0x8000_0000, hi = 0 (the natural magnitude result, no trap).
- **Operand stability:** `a`, `b`, and `op` are don't-care after the start cycle. Operands are latched.
- **start while busy:** ignored and not queued. The hazard logic must not assert it.
- **Register stability:** `hi` and `lo` hold their values throughout CALC and change only in FIX or on MTHI/MTLO.

## Timing
- **Reset:** `rst`=1 forces state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, all immediately (asynchronous). Reset asserted mid-operation aborts it, with no partial HI/LO write.
- **Mult/div latency:** if start is accepted at posedge k:
  - `busy`=1 after posedge k.
  - CALC occupies posedges k+1 … k+32.
  - FIX occurs at posedge k+33, where `hi`/`lo` update and `busy` falls.
  - `done`=1 for exactly the cycle after posedge k+33, during which `busy`=0.
  - Total: 33 cycles from accept to results visible.
- **Back-to-back:** a new start is accepted at posedge k+34 at the earliest, i.e. in the cycle `done` is high.
- **MTHI/MTLO:** `hi`/`lo` is visible after posedge k, and `busy` never rises.

## Test plan
- **Reset mid-operation:** MULTU a=3, b=5, then assert `rst` 10 cycles later. `busy`, `done`, `hi`, `lo` all go to 0 immediately. A subsequent MTLO a=7 gives lo=7.
- **MULTU full width:** a=0xFFFF_FFFF, b=0xFFFF_FFFF gives hi=0xFFFF_FFFE, lo=0x0000_0001. `busy` is high for exactly 33 cycles and `done` pulses once.
- **MULT signed:** a=-7 (0xFFFF_FFF9), b=6 gives hi=0xFFFF_FFFF, lo=0xFFFF_FFD6 (-42). Repeat with a=-7, b=-6, which gives hi=0, lo=42.
- **DIV signed:** a=-17, b=5 gives lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFE (-2). DIVU a=100, b=7 gives lo=14, hi=2.
- **Divide edge cases:** DIVU a=0x1234, b=0 gives hi=0x1234, lo=0xFFFF_FFFF after 33 cycles. DIV 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0.
- **Ignored start and back-to-back:** start=1 with MTHI a=9 at cycle 5 of a busy MULTU leaves hi unchanged until FIX writes the product. A new DIVU issued in the `done` cycle is accepted, and its own `done` follows 33 cycles later.
